seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 157 +++++++++++++++
 tb/tb_seg_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan -- 4-digit multiplexed 7-segment scanner with leading-zero
// blanking and zero-flag driven blinking.
//
// A prescaler divides CLK into digit-slot ticks; a 2-bit index walks the four
// digit slots. Each clock the outputs are registered from the current slot,
// the digit inputs, the blanking enable and the blink phase, so any input
// change shows up on AN/SEG exactly one clock later.
//
// Parameters:
//   DIV           clocks per digit slot (2..65535)
//   BLINK_FRAMES  full 4-digit frames per blink half-period (1..255)
//
// Ports:
//   CLK   in   1  system clock, rising edge
//   MR    in   1  asynchronous active-low master reset
//   EN    in   1  scan enable; 0 freezes prescaler, index and blink state
//   D0    in   4  BCD units digit
//   D1    in   4  BCD tens digit
//   D2    in   4  BCD hundreds digit
//   D3    in   4  BCD thousands digit
//   CO    in   1  zero flag; 1 requests blinking
//   LZB   in   1  leading-zero blanking enable
//   AN    out  4  digit selects, active-low, AN[i] selects Di
//   SEG   out  7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_scan #(
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       CLK,
  input  logic       MR,
  input  logic       EN,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic       CO,
  input  logic       LZB,
  output logic [3:0] AN,
  output logic [6:0] SEG
);

  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [15:0] presc_reg, presc_next;
  logic [1:0]  idx_reg, idx_next;
  logic [7:0]  blink_cnt_reg, blink_cnt_next;
  logic        phase_reg, phase_next;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;

  logic        tick;
  logic        frame_end;
  logic [15:0] digs;
  logic [3:0]  blank_vec;
  logic [3:0]  cur_digit;

  assign digs      = {D3, D2, D1, D0};
  assign tick      = (presc_reg == DIV_LAST) & EN;
  assign frame_end = tick & (idx_reg == 2'd3);

  // A slot is blanked when its digit and every higher digit are zero.
  // The units digit always shows, so a value of zero reads "0".
  assign blank_vec[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign blank_vec[gi] = LZB & ~|digs[15:4*gi];
    end
  endgenerate

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    case (idx_reg)
      2'd0:    cur_digit = D0;
      2'd1:    cur_digit = D1;
      2'd2:    cur_digit = D2;
      default: cur_digit = D3;
    endcase
  end

  // Scan counters: EN low holds everything in place.
  always_comb begin
    presc_next = presc_reg;
    idx_next   = idx_reg;
    if (EN) begin
      if (tick) begin
        presc_next = 16'd0;
        idx_next   = idx_reg + 2'd1;
      end else begin
        presc_next = presc_reg + 16'd1;
      end
    end
  end

  // Blink state only advances on frame boundaries while CO is high; dropping
  // CO restores visibility on the very next clock.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    if (!CO) begin
      blink_cnt_next = 8'd0;
      phase_next     = 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = 8'd0;
        phase_next     = ~phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    if (phase_reg && !blank_vec[idx_reg]) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = decode(cur_digit);
    end
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      presc_reg     <= 16'd0;
      idx_reg       <= 2'd0;
      blink_cnt_reg <= 8'd0;
      phase_reg     <= 1'b1;
      AN            <= 4'b1111;
      SEG           <= 7'b1111111;
    end else begin
      presc_reg     <= presc_next;
      idx_reg       <= idx_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      AN            <= an_next;
      SEG           <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan -- directed self-checking bench for seg_scan with DIV=4 and
// BLINK_FRAMES=2 (16 clocks per frame). Expected values are hand-derived
// segment patterns and digit-select codes.
// -----------------------------------------------------------------------------
module tb_seg_scan;

  logic       CLK = 1'b0;
  logic       MR  = 1'b0;
  logic       EN  = 1'b0;
  logic [3:0] D0  = 4'd0;
  logic [3:0] D1  = 4'd0;
  logic [3:0] D2  = 4'd0;
  logic [3:0] D3  = 4'd0;
  logic       CO  = 1'b0;
  logic       LZB = 1'b0;
  logic [3:0] AN;
  logic [6:0] SEG;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SX = 7'b1111111;

  seg_scan #(.DIV(4), .BLINK_FRAMES(2)) dut (
    .CLK(CLK), .MR(MR), .EN(EN),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .CO(CO), .LZB(LZB), .AN(AN), .SEG(SEG)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Run one 16-clock frame, checking every clock against per-slot tables.
  task automatic frame(input string tag, input logic [3:0] an_t [4], input logic [6:0] seg_t [4]);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("%s_an_s%0d_c%0d", tag, s, c), {3'b000, AN}, {3'b000, an_t[s]});
        chk($sformatf("%s_seg_s%0d_c%0d", tag, s, c), SEG, seg_t[s]);
      end
    end
    $display("frame %s done: checks=%0d errors=%0d", tag, checks, errors);
  endtask

  logic [3:0] an_lit [4];
  logic [3:0] an_lzb [4];
  logic [3:0] an_dark [4];
  logic [6:0] seg_1234 [4];
  logic [6:0] seg_0050 [4];
  logic [6:0] seg_0050_lzb [4];
  logic [6:0] seg_dark [4];

  initial begin
    an_lit       = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    an_lzb       = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    an_dark      = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};
    seg_1234     = '{S4, S3, S2, S1};
    seg_0050     = '{S0, S5, S0, S0};
    seg_0050_lzb = '{S0, S5, SX, SX};
    seg_dark     = '{SX, SX, SX, SX};

    // Reset held across several clocks: outputs stay dark.
    D3 = 4'd1; D2 = 4'd2; D1 = 4'd3; D0 = 4'd4;
    EN = 1'b1;
    repeat (3) step();
    chk("reset_an", {3'b000, AN}, 7'b0001111);
    chk("reset_seg", SEG, SX);
    $display("reset checked: AN=%b SEG=%b", AN, SEG);

    // Release reset; first edge shows slot 0.
    MR = 1'b1;
    frame("scan1234", an_lit, seg_1234);

    // Leading-zero blanking on 0050, then same digits unblanked.
    D3 = 4'd0; D2 = 4'd0; D1 = 4'd5; D0 = 4'd0; LZB = 1'b1;
    frame("lzb_on", an_lzb, seg_0050_lzb);
    LZB = 1'b0;
    frame("lzb_off", an_lit, seg_0050);

    // Non-BCD code on D0 decodes to all segments off while selected.
    D0 = 4'b1100;
    step();
    chk("nonbcd_an", {3'b000, AN}, 7'b0001110);
    chk("nonbcd_seg", SEG, SX);
    $display("non-bcd slot0: AN=%b SEG=%b", AN, SEG);
    repeat (15) step();

    // Blinking: 2 visible frames, 2 dark, then visible again.
    D3 = 4'd1; D2 = 4'd2; D1 = 4'd3; D0 = 4'd4;
    CO = 1'b1;
    frame("blink_vis1a", an_lit, seg_1234);
    frame("blink_vis1b", an_lit, seg_1234);
    frame("blink_dark1a", an_dark, seg_dark);
    frame("blink_dark1b", an_dark, seg_dark);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("blink_vis2_an_c%0d", c), {3'b000, AN}, 7'b0001110);
      chk($sformatf("blink_vis2_seg_c%0d", c), SEG, S4);
    end
    repeat (28) step();
    // Second dark period: check slots 0 and 1, then drop CO.
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("blink_dark2_an_c%0d", c), {3'b000, AN}, 7'b0001111);
    end
    CO = 1'b0;
    step();
    chk("co_drop_edge1_an", {3'b000, AN}, 7'b0001111);
    step();
    chk("co_drop_edge2_an", {3'b000, AN}, 7'b0001011);
    chk("co_drop_edge2_seg", SEG, S2);
    $display("co dropped: AN=%b SEG=%b", AN, SEG);
    repeat (6) step();

    // Scan freeze inside slot 2 with a digit change while frozen.
    D2 = 4'd7;
    repeat (10) step();
    EN = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("freeze_an_c%0d", c), {3'b000, AN}, 7'b0001011);
      chk($sformatf("freeze_seg7_c%0d", c), SEG, S7);
    end
    D2 = 4'd8;
    step();
    chk("freeze_d2chg_an", {3'b000, AN}, 7'b0001011);
    chk("freeze_d2chg_seg", SEG, S8);
    repeat (4) step();
    chk("freeze_end_an", {3'b000, AN}, 7'b0001011);
    $display("freeze done: AN=%b SEG=%b", AN, SEG);
    // Prescaler was frozen at 2: two more slot-2 clocks, then slot 3.
    EN = 1'b1;
    step();
    chk("resume_e1_an", {3'b000, AN}, 7'b0001011);
    step();
    chk("resume_e2_an", {3'b000, AN}, 7'b0001011);
    step();
    chk("resume_e3_an", {3'b000, AN}, 7'b0000111);
    chk("resume_e3_seg", SEG, S1);
    $display("resume: AN=%b SEG=%b", AN, SEG);

    // Asynchronous reset mid slot 3, checked before any clock edge.
    MR = 1'b0;
    #2;
    chk("async_rst_an", {3'b000, AN}, 7'b0001111);
    chk("async_rst_seg", SEG, SX);
    @(negedge CLK);
    MR = 1'b1;
    step();
    chk("post_rst_an", {3'b000, AN}, 7'b0001110);
    chk("post_rst_seg", SEG, S4);
    $display("async reset: AN=%b SEG=%b", AN, SEG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
